// File: rtl/saturn_debug_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : saturn_debug_tx_arbiter_if
//  Description : Two byte-message sources plus the shared debug character sink.
//  Revision    : 1.0  initial release
// ============================================================================
interface saturn_debug_tx_arbiter_if;
    logic       i_req0_valid;
    logic [7:0] i_req0_char;
    logic       i_req0_last;
    logic       o_req0_ready;
    logic       i_req1_valid;
    logic [7:0] i_req1_char;
    logic       i_req1_last;
    logic       o_req1_ready;
    logic       o_tx_valid;
    logic [7:0] o_tx_char;
    logic       i_tx_ready;
    logic [1:0] o_grant;
    logic       o_busy;
    logic [7:0] o_abort_ctr;

    modport master (
        output i_req0_valid, i_req0_char, i_req0_last,
        input  o_req0_ready,
        output i_req1_valid, i_req1_char, i_req1_last,
        input  o_req1_ready,
        input  o_tx_valid, o_tx_char,
        output i_tx_ready,
        input  o_grant, o_busy, o_abort_ctr
    );

    modport slave (
        input  i_req0_valid, i_req0_char, i_req0_last,
        output o_req0_ready,
        input  i_req1_valid, i_req1_char, i_req1_last,
        output o_req1_ready,
        output o_tx_valid, o_tx_char,
        input  i_tx_ready,
        output o_grant, o_busy, o_abort_ctr
    );
endinterface
`default_nettype wire

// File: rtl/saturn_debug_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : saturn_debug_tx_arbiter
//  Description : Message-granular round-robin arbiter for the debug byte sink,
//                with stall timeout and length cap. SATURN_DBG_TX_CRLF_EN
//                appends CR LF after every message.
//  Revision    : 1.0  initial release
// ============================================================================
module saturn_debug_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1000,
    parameter logic [8:0]  MAX_LEN = 9'd511
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clk_en,
    saturn_debug_tx_arbiter_if.slave  dbg
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_XFER    = 3'd1,
        S_ABORT   = 3'd2,
        S_TERM_CR = 3'd3,
        S_TERM_LF = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_winner_q, last_winner_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_char_q, tx_char_d;
    logic [7:0]  abort_ctr_q, abort_ctr_d;
    logic [8:0]  len_q, len_d;
    logic [15:0] tmo_q, tmo_d;

    logic        w_slot_free;
    logic        w_sel_valid;
    logic [7:0]  w_sel_char;
    logic        w_sel_last;
    logic        w_xfer_ok;
    logic        w_accept;
    logic        w_eom;
    logic        w_pick1;

    assign w_slot_free = !tx_valid_q || dbg.i_tx_ready;
    assign w_sel_valid = grant_q[1] ? dbg.i_req1_valid : dbg.i_req0_valid;
    assign w_sel_char  = grant_q[1] ? dbg.i_req1_char  : dbg.i_req0_char;
    assign w_sel_last  = grant_q[1] ? dbg.i_req1_last  : dbg.i_req0_last;
    assign w_xfer_ok   = i_clk_en && (state_q == S_XFER) && w_slot_free;
    assign w_accept    = w_xfer_ok && w_sel_valid;

    assign dbg.o_req0_ready = w_xfer_ok && grant_q[0];
    assign dbg.o_req1_ready = w_xfer_ok && grant_q[1];
    assign dbg.o_tx_valid   = tx_valid_q;
    assign dbg.o_tx_char    = tx_char_q;
    assign dbg.o_grant      = grant_q;
    assign dbg.o_busy       = (state_q != S_IDLE) || tx_valid_q;
    assign dbg.o_abort_ctr  = abort_ctr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            grant_q       <= 2'b00;
            last_winner_q <= 1'b1;
            tx_valid_q    <= 1'b0;
            tx_char_q     <= 8'h00;
            abort_ctr_q   <= 8'h00;
            len_q         <= 9'd0;
            tmo_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            tx_valid_q    <= tx_valid_d;
            tx_char_q     <= tx_char_d;
            abort_ctr_q   <= abort_ctr_d;
            len_q         <= len_d;
            tmo_q         <= tmo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        tx_valid_d    = tx_valid_q;
        tx_char_d     = tx_char_q;
        abort_ctr_d   = abort_ctr_q;
        len_d         = len_q;
        tmo_d         = tmo_q;
        w_eom         = 1'b0;
        w_pick1       = 1'b0;

        if (i_clk_en) begin
            // A sink handshake empties the slot; any load below overrides it.
            if (tx_valid_q && dbg.i_tx_ready) begin
                tx_valid_d = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (dbg.i_req0_valid || dbg.i_req1_valid) begin
                        w_pick1 = (dbg.i_req0_valid && dbg.i_req1_valid) ?
                                  !last_winner_q : dbg.i_req1_valid;
                        grant_d = w_pick1 ? 2'b10 : 2'b01;
                        len_d   = 9'd0;
                        tmo_d   = 16'd0;
                        state_d = S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        tx_char_d  = w_sel_char;
                        tx_valid_d = 1'b1;
                        len_d      = len_q + 9'd1;
                        tmo_d      = 16'd0;
                        w_eom      = w_sel_last || (len_q == MAX_LEN - 9'd1);
                    end else if (!w_sel_valid) begin
                        if (tmo_q == TIMEOUT - 16'd1) begin
                            state_d = S_ABORT;
                        end else begin
                            tmo_d = tmo_q + 16'd1;
                        end
                    end
                end
                S_ABORT: begin
                    if (w_slot_free) begin
                        tx_char_d  = 8'h7E;
                        tx_valid_d = 1'b1;
                        if (abort_ctr_q != 8'hFF) begin
                            abort_ctr_d = abort_ctr_q + 8'd1;
                        end
                        w_eom = 1'b1;
                    end
                end
                S_TERM_CR: begin
                    if (w_slot_free) begin
                        tx_char_d  = 8'h0D;
                        tx_valid_d = 1'b1;
                        state_d    = S_TERM_LF;
                    end
                end
                S_TERM_LF: begin
                    if (w_slot_free) begin
                        tx_char_d  = 8'h0A;
                        tx_valid_d = 1'b1;
                        grant_d    = 2'b00;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            endcase

            if (w_eom) begin
                last_winner_d = grant_q[1];
`ifdef SATURN_DBG_TX_CRLF_EN
                state_d       = S_TERM_CR;
`else
                grant_d       = 2'b00;
                state_d       = S_IDLE;
`endif
            end
        end
    end
endmodule
`default_nettype wire
